// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a borrow flop.
// Start/busy/done handshake; WIDTH shift cycles per operation.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      d        = sa[0] ^ sb[0] ^ br;
      br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_next = {d, res[WIDTH-1:1]};
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // DONE accepts a new start so operations can run back to back
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  res   <= '0;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sa  <= {1'b0, sa[WIDTH-1:1]};
               sb  <= {1'b0, sb[WIDTH-1:1]};
               br  <= br_next;
               res <= res_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff  <= res_next;
                  bout  <= br_next;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases at WIDTH=8, then
// random vectors at WIDTH=8 and WIDTH=13 against an arithmetic model.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [7:0]  diff8;
   logic        bout8, busy8, done8;
   logic        start13 = 1'b0;
   logic [12:0] a13 = '0;
   logic [12:0] b13 = '0;
   logic [12:0] diff13;
   logic        bout13, busy13, done13;

   int compared = 0;
   int failed   = 0;
   int cyc      = 0;
   int run8     = 0;
   int run13    = 0;

   typedef struct {
      logic [15:0] diff;
      logic        bout;
      int          acc;
   } exp_t;

   exp_t q8[$];
   exp_t q13[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
   );

   serial_subtractor #(.WIDTH(13)) u_dut13 (
      .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13),
      .diff(diff13), .bout(bout13), .busy(busy13), .done(done13)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // done must appear WIDTH edges after the accepting edge (cycle WIDTH+1)
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         run8  = 0;
         run13 = 0;
      end else begin
         if (busy8) run8++;
         if (busy13) run13++;
         if (done8) begin
            if (q8.size() == 0) begin
               check("w8_unexpected_done", 1, 0);
            end else begin
               e = q8.pop_front();
               check("w8_diff", diff8, e.diff);
               check("w8_bout", bout8, e.bout);
               check("w8_latency", cyc - e.acc, 8);
               check("w8_busy_cycles", run8, 8);
               check("w8_busy_with_done", busy8, 0);
            end
            run8 = 0;
         end
         if (done13) begin
            if (q13.size() == 0) begin
               check("w13_unexpected_done", 1, 0);
            end else begin
               e = q13.pop_front();
               check("w13_diff", diff13, e.diff);
               check("w13_bout", bout13, e.bout);
               check("w13_latency", cyc - e.acc, 13);
               check("w13_busy_cycles", run13, 13);
               check("w13_busy_with_done", busy13, 0);
            end
            run13 = 0;
         end
      end
   end

   // Waits until the DUT can accept (IDLE or DONE), then issues one start.
   task automatic op8(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] ed, input logic eb, input bit push);
      int n = 0;
      @(negedge clk);
      while (busy8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy8) check("w8_wait_timeout", 1, 0);
      start8 = 1'b1;
      a8     = x;
      b8     = y;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      if (push) q8.push_back('{diff: 16'(ed), bout: eb, acc: cyc});
   endtask

   task automatic op13(input logic [12:0] x, input logic [12:0] y);
      int n = 0;
      logic [12:0] ed;
      ed = x - y;
      @(negedge clk);
      while (busy13 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy13) check("w13_wait_timeout", 1, 0);
      start13 = 1'b1;
      a13     = x;
      b13     = y;
      @(posedge clk);
      #1;
      start13 = 1'b0;
      a13     = 13'($urandom);
      b13     = 13'($urandom);
      q13.push_back('{diff: 16'(ed), bout: (x < y), acc: cyc});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [7:0]  x8, y8;
      logic [12:0] x13, y13;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy8, 0);
      check("reset_done", done8, 0);
      check("reset_diff", diff8, 0);
      check("reset_bout", bout8, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors, hand-computed results
      op8(8'd100, 8'd37,  8'd63,  1'b0, 1'b1);
      op8(8'd5,   8'd10,  8'd251, 1'b1, 1'b1);
      op8(8'd0,   8'd1,   8'd255, 1'b1, 1'b1);
      op8(8'd0,   8'd0,   8'd0,   1'b0, 1'b1);
      op8(8'd255, 8'd255, 8'd0,   1'b0, 1'b1);

      // Start during SHIFT must be ignored
      op8(8'd200, 8'd50, 8'd150, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      start8 = 1'b1;
      a8     = 8'd1;
      b8     = 8'd2;
      @(negedge clk);
      start8 = 1'b0;

      // Back to back: second start lands in the DONE cycle of the first
      op8(8'd9, 8'd3, 8'd6,   1'b0, 1'b1);
      op8(8'd3, 8'd9, 8'd250, 1'b1, 1'b1);

      // Reset mid-operation aborts without a done pulse
      op8(8'd77, 8'd11, 8'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_diff", diff8, 0);
      check("abort_bout", bout8, 0);
      @(negedge clk);
      rst = 1'b0;
      op8(8'd77, 8'd11, 8'd66, 1'b0, 1'b1);

      // Random regression
      for (int i = 0; i < 600; i++) begin
         x8 = 8'($urandom);
         y8 = (i % 7 == 0) ? x8 : 8'($urandom);
         op8(x8, y8, x8 - y8, (x8 < y8), 1'b1);
      end
      for (int i = 0; i < 500; i++) begin
         x13 = 13'($urandom);
         y13 = (i % 7 == 0) ? x13 : 13'($urandom);
         op13(x13, y13);
      end

      n = 0;
      while ((q8.size() != 0 || q13.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      check("w8_queue_drained", q8.size(), 0);
      check("w13_queue_drained", q13.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing a - b LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the subtract counterpart of the team's adder datapath, for area-constrained arithmetic units where latency is traded for gate count. A start/busy/done handshake lets a controller launch an operation and collect the result.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  launch request; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; captured on an accepted start.
b  input  WIDTH  subtrahend; captured on an accepted start.
diff  output  WIDTH  result a - b modulo 2^WIDTH.
bout  output  1  final borrow; 1 when a < b (unsigned).
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when diff and bout become valid.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): state goes to IDLE. diff, bout, busy, done, borrow register, bit counter and shift registers all clear to 0. rst has priority over every other input.
- FSM states: IDLE, SHIFT, DONE.
- Start accepted (start=1 in IDLE or DONE):
  - a goes to sa, b goes to sb.
  - Borrow register br clears to 0. Counter clears to 0. Result shift register clears to 0.
  - State goes to SHIFT; busy=1 from the next cycle.
  - diff and bout keep their previous values until the new result completes.
- SHIFT, per cycle:
  - Difference bit d = sa[0] ^ sb[0] ^ br.
  - Borrow out: br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by 1.
  - d shifts into the result register at the MSB; the result register shifts right.
  - Counter increments.
- Exactly WIDTH SHIFT cycles. On the last one (counter = WIDTH-1):
  - The completed result register is copied to diff, and br_next to bout.
  - State goes to DONE.
- DONE, held for one cycle:
  - done=1, busy=0.
  - If start=1 in this cycle, a new operation is accepted (back-to-back operation). done still pulses for the finished result.
  - Otherwise, next state is IDLE.
- Latency: start accepted at edge 0 → busy high for cycles 1..WIDTH → done high in cycle WIDTH+1. diff and bout are valid from cycle WIDTH+1 and held until the next operation completes.
- start=1 during SHIFT is ignored: there is no queueing, and the operands of the operation in flight are unaffected.
- a and b may change freely after the accepting edge.
- done is never high while busy is high. busy and done are both 0 in IDLE.
- Reset in mid-operation aborts the operation. No done pulse is produced, and diff and bout go to 0.
- Arithmetic: diff equals (a - b) mod 2^WIDTH. bout = 1 exactly when a < b as unsigned values. A signed overflow flag is not produced.

Test Plan:
1. Reset, then WIDTH=8, a=100, b=37, pulse start → busy=1 for 8 cycles, done pulse in cycle 9, diff=63, bout=0.
2. a=5, b=10 → diff=251 (0xFB), bout=1. a=0, b=1 → diff=255, bout=1. a=0, b=0 → diff=0, bout=0. a=255, b=255 → diff=0, bout=0.
3. Start a=200, b=50. Assert start again with a=1, b=2 at cycle 4 (mid-SHIFT) → second start ignored: diff=150, bout=0, exactly one done pulse.
4. Start a=9, b=3. Hold start=1 during the DONE cycle with a=3, b=9 → done pulses with diff=6; the second op then runs, and the next done gives diff=250, bout=1. There are no idle cycles between the two operations.
5. Start a=77, b=11. Assert rst at cycle 5 → in the next cycle busy=0, done=0, diff=0, bout=0, no done pulse. A fresh start then works normally (66, bout=0).
6. Random regression (≥1000 vectors, WIDTH=8 and WIDTH=13) against a reference model of (a - b) mod 2^WIDTH and a<b. Check the done-to-start latency is exactly WIDTH+1 every time.
